seq_detect_ctrl: RTL
====================

# seq_detect_ctrl

Run-time configurable controller for overlapping serial pattern detection. It accepts a pattern, length and match threshold over a valid/ready config handshake, then sequences a detection run over a gated serial bit stream. It counts overlapping matches and raises `done` when the threshold is reached. It sits between the control register interface and a serial input lane, replacing per-pattern hard-coded detector FSMs.

## Interface
- `MAX_LEN`, 8, longest supported pattern in bits (2..15)
- `LEN_W`, 4, width of `cfg_len`; requires MAX_LEN ≤ 2**LEN_W−1
- `CNT_W`, 8, width of match counter and threshold
- `clk` in 1: clock, all logic on rising edge
- `reset` in 1: reset, synchronous, active-high
- `cfg_valid` in 1: config offer
- `cfg_ready` out 1: config accept window
- `cfg_pattern` in MAX_LEN: pattern; bit [len−1] is the oldest bit, bit [0] is the newest
- `cfg_len` in LEN_W: pattern length, legal range 1..MAX_LEN
- `cfg_threshold` in CNT_W: matches required for done, legal range ≥1
- `start` in 1: begin run (single-cycle strobe)
- `stop` in 1: abort run (single-cycle strobe)
- `bit_valid` in 1: qualifies `bit_in`
- `bit_in` in 1: serial data
- `match` out 1: one-cycle pulse per detected occurrence
- `match_count` out CNT_W: matches counted in current run
- `busy` out 1: high in RUN
- `done` out 1: high in DONE
- `err_cfg` out 1: one-cycle pulse on rejected config

## Operation
- States: IDLE, ARMED, RUN, DONE (encoded register, default branch → IDLE).
- IDLE:
  - `cfg_ready`=1.
  - Handshake (`cfg_valid`&`cfg_ready`) with legal len and threshold: latch pattern/len/threshold → ARMED.
  - Handshake with illegal len (0 or >MAX_LEN) or threshold 0: `err_cfg` pulse, stay IDLE, latched config unchanged.
  - `start` ignored.
- ARMED:
  - `cfg_ready`=1; a legal handshake re-latches config (stays ARMED); an illegal one pulses `err_cfg`, keeps the old config and stays ARMED.
  - `start` → RUN: clear history, fill counter, `match_count`.
  - If `cfg_valid` and `start` coincide, the config wins and `start` is ignored. `stop` has no effect.
- RUN:
  - `cfg_ready`=0.
  - Each `bit_valid` cycle: history ← {history[MAX_LEN−2:0], bit_in}; fill counter increments, saturating at MAX_LEN.
  - Match when the new history[len−1:0] equals pattern[len−1:0] and the new fill ≥ len.
  - Overlap inherent: no history flush on match.
  - On match: `match` pulses, `match_count`+1; if the new count equals threshold → DONE.
  - `stop` → ARMED with `match_count` held; stop has priority over a same-cycle match (bit discarded, no pulse, no count).
  - `start` ignored. `bit_valid`=0 holds all state.
- DONE:
  - `cfg_ready`=1; `bit_in` ignored; `match_count` holds at threshold.
  - `start` → RUN with clears as above.
  - Legal handshake → ARMED with the new config; handshake wins over a same-cycle `start`. Illegal handshake pulses `err_cfg` and stays DONE.
- Reset, including mid-run: → IDLE, config registers cleared, history and fill cleared.

## Timing
- Reset values: `cfg_ready`=1, `match`=0, `match_count`=0, `busy`=0, `done`=0, `err_cfg`=0.
- All outputs are registered; Moore style, no combinational path from inputs.
- Match latency: bit sampled at edge k → `match` high and `match_count` updated during cycle k..k+1. `done` rises at the same edge, `busy` falls at the same edge.
- Config latency: accepted at edge k → ARMED from edge k; `start` is honoured from the next cycle.
- `err_cfg` asserts the cycle after the offending handshake, for one cycle.
- `start` at edge k → `busy`=1 after edge k; first bit is usable at edge k+1.
- Throughput: one bit per cycle, back-to-back matches allowed (len=1).

## Test plan
- Config pattern=0x0D, len=4, thr=3; start; bits 1,1,0,1,1,0,1 → `match` pulses after bits 4 and 7, `match_count`=2, `busy`=1, `done`=0.
- Same config, thr=2, same stream → `done`=1 and `busy`=0 after bit 7. Further bits do not change count 2. `start` → count 0, `busy`=1.
- len=0 config in IDLE → `err_cfg` one-cycle pulse, stays IDLE. Legal config in ARMED, then illegal len=9 → `err_cfg` pulse, old pattern still detected.
- len=1, pattern=1, thr=255, bits 1,1,1 with `bit_valid` toggling 1,0,1,0,1 → exactly 3 match pulses, count 3, no counting on invalid cycles.
- RUN, `stop` coincident with the completing bit of 1101 → no match, state ARMED, count held. `start` then 1,1,0,1 → count 1.
- Reset asserted mid-run after 1,1,0 → all outputs at reset values, `cfg_ready`=1. `start` without new config is ignored.

Source files
------------

// File: rtl/seq_detect_ctrl_if.sv
// rtl/seq_detect_ctrl_if.sv - config, run-control and serial-lane bundle for seq_detect_ctrl
// The master drives config, strobes and bits; the slave (the detector) returns status.
interface seq_detect_ctrl_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic [CNT_W-1:0]   cfg_threshold;
  logic               start;
  logic               stop;
  logic               bit_valid;
  logic               bit_in;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic               busy;
  logic               done;
  logic               err_cfg;

  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_threshold,
    output start, stop, bit_valid, bit_in,
    input  cfg_ready, match, match_count, busy, done, err_cfg
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_threshold,
    input  start, stop, bit_valid, bit_in,
    output cfg_ready, match, match_count, busy, done, err_cfg
  );
endinterface

// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - run-time configurable overlapping serial pattern detector
// All outputs come from registers or decoded state; no input reaches an output combinationally.
module seq_detect_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input logic             clk_i,
  input logic             reset_i,
  seq_detect_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   thr_q, thr_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               match_q, match_d;
  logic               err_q, err_d;

  logic               cfg_legal;
  logic [MAX_LEN-1:0] hist_new;
  logic [LEN_W-1:0]   fill_new;
  logic [MAX_LEN-1:0] len_mask;
  logic               hit;
  logic [CNT_W-1:0]   count_inc;

  assign cfg_legal = (bus.cfg_len != '0) &&
                     (bus.cfg_len <= LEN_W'(MAX_LEN)) &&
                     (bus.cfg_threshold != '0);

  // Candidate history/fill if the current bit were accepted; fill saturates at MAX_LEN.
  assign hist_new  = {hist_q[MAX_LEN-2:0], bus.bit_in};
  assign fill_new  = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
  assign count_inc = count_q + CNT_W'(1);

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
  end

  assign hit = (((hist_new ^ pattern_q) & len_mask) == '0) && (fill_new >= len_q);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      pattern_q <= '0;
      len_q     <= '0;
      thr_q     <= '0;
      hist_q    <= '0;
      fill_q    <= '0;
      count_q   <= '0;
      match_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      thr_q     <= thr_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      count_q   <= count_d;
      match_q   <= match_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    thr_d     = thr_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    count_d   = count_q;
    match_d   = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.cfg_valid) begin
          if (cfg_legal) begin
            pattern_d = bus.cfg_pattern;
            len_d     = bus.cfg_len;
            thr_d     = bus.cfg_threshold;
            state_d   = ST_ARMED;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_ARMED: begin
        // A config offer, legal or not, takes precedence over a same-cycle start.
        if (bus.cfg_valid) begin
          if (cfg_legal) begin
            pattern_d = bus.cfg_pattern;
            len_d     = bus.cfg_len;
            thr_d     = bus.cfg_threshold;
          end else begin
            err_d = 1'b1;
          end
        end else if (bus.start) begin
          hist_d  = '0;
          fill_d  = '0;
          count_d = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (bus.stop) begin
          state_d = ST_ARMED;
        end else if (bus.bit_valid) begin
          hist_d = hist_new;
          fill_d = fill_new;
          if (hit) begin
            match_d = 1'b1;
            count_d = count_inc;
            if (count_inc == thr_q) begin
              state_d = ST_DONE;
            end
          end
        end
      end

      ST_DONE: begin
        if (bus.cfg_valid) begin
          if (cfg_legal) begin
            pattern_d = bus.cfg_pattern;
            len_d     = bus.cfg_len;
            thr_d     = bus.cfg_threshold;
            state_d   = ST_ARMED;
          end else begin
            err_d = 1'b1;
          end
        end else if (bus.start) begin
          hist_d  = '0;
          fill_d  = '0;
          count_d = '0;
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.cfg_ready   = (state_q != ST_RUN);
  assign bus.busy        = (state_q == ST_RUN);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.match       = match_q;
  assign bus.match_count = count_q;
  assign bus.err_cfg     = err_q;

endmodule
